// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU.
//   - MIPS funct codes accepted on the signal input
//   - FSM state encoding (IDLE/MUL/FIN)
//   - operation select for the 1-bit ALU slice
package alu_pkg;

    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_SLT   = 6'd42;
    localparam logic [5:0] F_MULTU = 6'd25;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIN  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_AND = 2'd0,
        OP_OR  = 2'd1,
        OP_ADD = 2'd2,
        OP_SLT = 2'd3
    } slice_op_t;

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle of the multi-cycle ALU.
//   start/signal/dataA/dataB : request, sampled when start=1 and the ALU is idle
//   busy                     : multiply in progress
//   done                     : one-cycle pulse, result/hi/lo/flags valid
//   result/hi/lo             : registered results
//   overflow/invalid         : flags of the last completed request
// master = requester (controller / bench), slave = the ALU.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       signal;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             overflow;
    logic             invalid;

    modport master (
        output start, signal, dataA, dataB,
        input  busy, done, result, hi, lo, overflow, invalid
    );

    modport slave (
        input  start, signal, dataA, dataB,
        output busy, done, result, hi, lo, overflow, invalid
    );
endinterface

// File: rtl/alu_slice.sv
// alu_slice: 1-bit ALU cell (AND / OR / full add / pass Less).
//   a, b     : operand bits
//   binvert  : invert b (subtract / compare)
//   cin/cout : ripple carry in/out
//   less     : value passed through for SLT (only bit 0 gets a non-zero one)
//   op       : operation select
//   result   : selected output bit
//   set      : raw sum bit, used at the MSB to form the SLT decision
module alu_slice
    import alu_pkg::*;
(
    input  logic      a,
    input  logic      b,
    input  logic      binvert,
    input  logic      cin,
    input  logic      less,
    input  slice_op_t op,
    output logic      result,
    output logic      cout,
    output logic      set
);
    logic bb;
    logic sum;

    always_comb begin
        bb   = b ^ binvert;
        sum  = a ^ bb ^ cin;
        cout = (a & bb) | (a & cin) | (bb & cin);
        set  = sum;
        result = 1'b0;
        case (op)
            OP_AND:  result = a & bb;
            OP_OR:   result = a | bb;
            OP_ADD:  result = sum;
            OP_SLT:  result = less;
            default: result = 1'b0;
        endcase
    end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU for the EX stage.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : alu_mc_if.slave (start/signal/dataA/dataB in; busy/done/result/hi/lo/overflow/invalid out)
// AND/OR/ADD/SUB/SLT go through a ripple chain of alu_slice cells and are
// registered on the start edge (done next cycle). MULTU runs a WIDTH-step
// shift-add into a 2*WIDTH accumulator; hi/lo and done appear in the FIN cycle.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic       clk,
    input  logic       reset,
    alu_mc_if.slave    bus
);
    state_t state, next_state;

    // Request decode
    slice_op_t op;
    logic      binv, is_single, is_add_sub, is_mul;

    always_comb begin
        op         = OP_AND;
        binv       = 1'b0;
        is_single  = 1'b1;
        is_add_sub = 1'b0;
        is_mul     = 1'b0;
        case (bus.signal)
            F_AND:   op = OP_AND;
            F_OR:    op = OP_OR;
            F_ADD:   begin op = OP_ADD; is_add_sub = 1'b1; end
            F_SUB:   begin op = OP_ADD; binv = 1'b1; is_add_sub = 1'b1; end
            F_SLT:   begin op = OP_SLT; binv = 1'b1; end
            F_MULTU: begin is_single = 1'b0; is_mul = 1'b1; end
            default: is_single = 1'b0;
        endcase
    end

    // Slice chain; each stage keeps its own carry so the chain is not one
    // self-dependent vector.
    logic [WIDTH-1:0] alu_res;
    logic             msb_set, msb_cin, msb_cout, alu_ovf, slt_bit;

    assign alu_ovf = msb_cin ^ msb_cout;
    // Sign of the true difference: raw MSB corrected when the subtract overflowed.
    assign slt_bit = msb_set ^ alu_ovf;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic cin, cout, res_bit, less_in;

        if (i == 0) begin : g_first
            assign cin = binv;
        end else begin : g_next
            assign cin = g_bit[i-1].cout;
        end

        assign less_in = (i == 0) ? slt_bit : 1'b0;

        if (i == WIDTH - 1) begin : g_msb
            alu_slice u_slice (
                .a(bus.dataA[i]), .b(bus.dataB[i]), .binvert(binv), .cin(cin),
                .less(less_in), .op(op), .result(res_bit), .cout(cout), .set(msb_set)
            );
            assign msb_cin  = cin;
            assign msb_cout = cout;
        end else begin : g_low
            logic set_unused;
            alu_slice u_slice (
                .a(bus.dataA[i]), .b(bus.dataB[i]), .binvert(binv), .cin(cin),
                .less(less_in), .op(op), .result(res_bit), .cout(cout), .set(set_unused)
            );
        end

        assign alu_res[i] = res_bit;
    end

    // Multiply datapath
    logic [2*WIDTH-1:0] mcand, acc, acc_step;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic               last_iter;

    assign acc_step  = mplier[0] ? acc + mcand : acc;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start && is_mul) next_state = MUL;
            MUL:     if (last_iter) next_state = FIN;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output / datapath registers
    logic [WIDTH-1:0] result_q, hi_q, lo_q;
    logic             done_q, ovf_q, inv_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            inv_q    <= 1'b0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (is_mul) begin
                            mcand  <= {{WIDTH{1'b0}}, bus.dataA};
                            mplier <= bus.dataB;
                            acc    <= '0;
                            cnt    <= '0;
                        end else if (is_single) begin
                            result_q <= alu_res;
                            ovf_q    <= is_add_sub & alu_ovf;
                            inv_q    <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            result_q <= '0;
                            ovf_q    <= 1'b0;
                            inv_q    <= 1'b1;
                            done_q   <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    // hi/lo/done are loaded on the edge into FIN so they are
                    // valid throughout the FIN cycle.
                    if (last_iter) begin
                        hi_q   <= acc_step[2*WIDTH-1:WIDTH];
                        lo_q   <= acc_step[WIDTH-1:0];
                        done_q <= 1'b1;
                        ovf_q  <= 1'b0;
                        inv_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state == MUL);
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.overflow = ovf_q;
    assign bus.invalid  = inv_q;
endmodule
